// File: rtl/axis_out.sv
//============================================================================
// Module      : axis_out
// Description : FIR result output stage; FIFO-buffered AXI-Stream master
//               with run-length counting, tlast generation and done pulse.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axis_out #(
  parameter int pDATA_WIDTH = 32,
  parameter int pLEN_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ap_start,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  input  logic [pDATA_WIDTH-1:0] fir_data,
  input  logic                   fir_valid,
  output logic                   out_ready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   ap_done,
  output logic                   ap_idle
);

  localparam int                  C_AW      = $clog2(FIFO_DEPTH);
  localparam logic [C_AW:0]       C_FULL    = (C_AW+1)'(FIFO_DEPTH);
  localparam logic [C_AW:0]       C_CNT_ONE = (C_AW+1)'(1);
  localparam logic [C_AW-1:0]     C_PTR_ONE = C_AW'(1);
  localparam logic [pLEN_WIDTH-1:0] C_LEN_ONE = pLEN_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [pLEN_WIDTH-1:0]   r_len;
  logic [pLEN_WIDTH-1:0]   r_in_cnt;
  logic [pLEN_WIDTH-1:0]   r_out_cnt;
  logic [C_AW-1:0]         r_wr_ptr;
  logic [C_AW-1:0]         r_rd_ptr;
  logic [C_AW:0]           r_count;
  logic                    r_done;
  logic [pDATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_last;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // Depends only on registered state, so sink backpressure never ripples back combinationally.
  assign out_ready = (r_state == ST_RUN) & ~w_full & (r_in_cnt != r_len);

  assign sm_tvalid = ~w_empty;
  assign sm_tdata  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign w_last    = ((r_out_cnt + C_LEN_ONE) == r_len);
  assign sm_tlast  = sm_tvalid & w_last;

  assign w_push = fir_valid & out_ready;
  assign w_pop  = sm_tvalid & sm_tready;

  assign ap_done = r_done;
  assign ap_idle = (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= fir_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        r_in_cnt <= r_in_cnt + C_LEN_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
        r_out_cnt <= r_out_cnt + C_LEN_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_len     <= data_length;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            // An empty run completes immediately without entering RUN.
            if (data_length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_pop && w_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/axis_out.md
# axis_out

Output stream stage of the FIR accelerator: accepts result samples from the FIR dataflow core and presents them as an AXI-Stream master toward the testbench/host. It buffers results in a small FIFO to absorb sink backpressure, counts samples against the programmed data length, generates `sm_tlast` on the final sample, and signals run completion to the control block. It sits directly downstream of the FIR core, opposite the input stream stage.

## Interface
- `pDATA_WIDTH`, 32, sample width.
- `pLEN_WIDTH`, 32, width of data-length register and sample counters.
- `FIFO_DEPTH`, 4, result buffer entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `ap_start` input 1: run start pulse from control.
- `data_length` input pLEN_WIDTH: samples in this run; sampled when `ap_start` is accepted.
- `fir_data` input pDATA_WIDTH: result sample from FIR core.
- `fir_valid` input 1: `fir_data` valid.
- `out_ready` output 1: stage can accept a result this cycle.
- `sm_tdata` output pDATA_WIDTH: stream data.
- `sm_tvalid` output 1: stream valid.
- `sm_tlast` output 1: marks final sample of run.
- `sm_tready` input 1: sink ready.
- `ap_done` output 1: one-cycle completion pulse.
- `ap_idle` output 1: stage idle.

## Operation
- States: IDLE, RUN.
- IDLE: `ap_idle`=1, `out_ready`=0. On `ap_start`=1: latch `data_length` into `len`, clear `in_cnt`/`out_cnt`, go RUN. If `data_length`=0: stay IDLE, pulse `ap_done` next cycle.
- RUN: `ap_idle`=0; `ap_start` ignored.
- Push: `out_ready` = RUN & FIFO not full & `in_cnt` != `len`. Accept when `fir_valid & out_ready`; write `fir_data`, `in_cnt`+1. `fir_valid` beyond `len` samples is never accepted.
- Pop: `sm_tvalid` = FIFO not empty. Handshake when `sm_tvalid & sm_tready`; `out_cnt`+1.
- `sm_tdata` = FIFO head when non-empty, else 0.
- `sm_tlast` = `sm_tvalid` & (`out_cnt` == `len`−1).
- Handshake with `sm_tlast`=1: next cycle state IDLE, `ap_done`=1 for exactly one cycle, `ap_idle`=1.
- FIFO: wr/rd pointers log2(FIFO_DEPTH) bits, wrap modulo depth; occupancy counter log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop: occupancy unchanged. Full: push blocked even if popping same cycle (`out_ready` depends only on registered occupancy). Empty: no pop.
- Counters compare with full pLEN_WIDTH; no wrap within a run.
- Reset (any state, including mid-run): state IDLE, FIFO flushed, counters 0. Outputs after reset: `sm_tvalid`=0, `sm_tdata`=0, `sm_tlast`=0, `out_ready`=0, `ap_done`=0, `ap_idle`=1.

## Timing
- `ap_start` sampled cycle N → RUN in N+1; `out_ready` may assert in N+1.
- Result accepted cycle N → visible on `sm_tdata`/`sm_tvalid` in N+1 (registered write, combinational read). Minimum latency 1 cycle.
- Throughput: 1 sample/cycle with `sm_tready` held high.
- AXI-Stream rule: once `sm_tvalid`=1, `sm_tvalid`, `sm_tdata`, `sm_tlast` stay stable until handshake.
- `out_ready` is a registered-state function only; no combinational path from `sm_tready` to `out_ready`.
- Last handshake cycle M → `ap_done`=1 and `ap_idle`=1 in M+1; new `ap_start` accepted from M+1.
- Length-0 run: `ap_start` cycle N → `ap_done` pulse cycle N+1, no stream beats.

## Test plan
- Basic: `data_length`=4, `fir_valid` continuous with 1,2,3,4, `sm_tready`=1 → beats 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance, `sm_tlast` only on 4, `ap_done` one cycle after beat 4.
- Backpressure/full: `data_length`=8, `sm_tready`=0 → exactly 4 accepted, `out_ready`=0, `sm_tdata`=first sample held stable; release `sm_tready` → all 8 delivered in order, tlast on 8th.
- Random `fir_valid`/`sm_tready` (50%), `data_length`=64 → output sequence equals input order, no loss/duplication, one `sm_tlast`, one `ap_done`.
- Overrun: `data_length`=3, FIR drives 5 valid samples → only first 3 accepted, `out_ready` low after 3rd.
- `data_length`=0 → `ap_done` next cycle, `sm_tvalid` never high; `ap_start` during RUN has no effect on `len`.
- Reset mid-run after 2 of 6 samples → next cycle all outputs at reset values, FIFO empty; fresh run of length 2 completes correctly.
